// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment multiplexer: glyph table,
// blank/off patterns, digit-index type and the leading-zero helper.
package seg7_pkg;

   typedef logic [1:0] digit_idx_t;

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   // Active-low {g,f,e,d,c,b,a}; entry [n] is the glyph for hex digit n.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

   // True when digit idx and every digit above it are zero; digit 0 never qualifies.
   function automatic logic lead_zero(input logic [15:0] value, input digit_idx_t idx);
      logic result;
      case (idx)
         2'd1:    result = (value[15:4] == 12'h000);
         2'd2:    result = (value[15:8] == 8'h00);
         2'd3:    result = (value[15:12] == 4'h0);
         default: result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_TABLE[nibble_i];
   end

endmodule

// File: rtl/seg7_mux.sv
// Time-multiplexed four-digit hex display driver with per-frame snapshot.
// Optional leading-zero blanking on digits 3..1 when SEG7_BLANK_EN is defined.
module seg7_mux
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] display,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        frame_tick
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   digit_idx_t    idx_q, idx_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          tick_q, tick_d;
   logic          term;
   logic          wrap;
   logic [3:0]    nibble;
   logic [6:0]    glyph;

   seg7_decode u_decode (
      .nibble_i (nibble),
      .seg_o    (glyph)
   );

   always_comb begin
      term     = (presc_q == PRESC_MAX);
      wrap     = term && (idx_q == 2'd3);
      presc_d  = term ? '0 : presc_q + 1'b1;
      idx_d    = term ? idx_q + 2'd1 : idx_q;
      shadow_d = wrap ? display : shadow_q;
      tick_d   = wrap;

      case (idx_q)
         2'd0:    nibble = shadow_q[3:0];
         2'd1:    nibble = shadow_q[7:4];
         2'd2:    nibble = shadow_q[11:8];
         default: nibble = shadow_q[15:12];
      endcase

      // NOTE: an/seg are built from the current idx_q/shadow_q and registered,
      // so the pins trail the index by exactly one cycle.
      an_d = ~(4'b0001 << idx_q);
`ifdef SEG7_BLANK_EN
      seg_d = lead_zero(shadow_q, idx_q) ? SEG_OFF : glyph;
`else
      seg_d = glyph;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q  <= '0;
         idx_q    <= 2'd0;
         shadow_q <= 16'h0000;
         an_q     <= AN_OFF;
         seg_q    <= SEG_OFF;
         tick_q   <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         tick_q   <= tick_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_mux.sv
// Directed bench for seg7_mux: a REFRESH_DIV=4 instance and a REFRESH_DIV=1 instance.
module tb_seg7_mux;

   localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                          G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                          G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                          G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011,
                          GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110,
                          GF = 7'b0001110, OFF = 7'b1111111;
   localparam int TICK_BUDGET = 200;

   typedef logic [3:0][6:0] glyphs_t;  // [k] = expected seg for digit k
   typedef struct {
      logic [15:0] disp;
      glyphs_t     plain;
      glyphs_t     blank;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst4, rst1;
   logic [15:0] disp4, disp1;
   logic [3:0]  an4, an1;
   logic [6:0]  seg4, seg1;
   logic        ft4, ft1;
   int          total = 0;
   int          bad = 0;
   vec_t        tbl[6];

   always #5 clk = ~clk;

   seg7_mux #(.REFRESH_DIV(4)) u_div4 (
      .clk(clk), .rst(rst4), .display(disp4), .an(an4), .seg(seg4), .frame_tick(ft4)
   );
   seg7_mux #(.REFRESH_DIV(1)) u_div1 (
      .clk(clk), .rst(rst1), .display(disp1), .an(an1), .seg(seg1), .frame_tick(ft1)
   );

   function automatic glyphs_t mk(input logic [6:0] g0, input logic [6:0] g1,
                                  input logic [6:0] g2, input logic [6:0] g3);
      glyphs_t g;
      g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
      return g;
   endfunction

   function automatic glyphs_t pick(input vec_t v);
`ifdef SEG7_BLANK_EN
      return v.blank;
`else
      return v.plain;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock, then sample #1 later; anodes of both instances must never have two digits lit.
   task automatic step();
      @(posedge clk);
      #1;
      check("an4_onehot", 32'($countones(~an4) <= 1), 1);
      check("an1_onehot", 32'($countones(~an1) <= 1), 1);
   endtask

   task automatic wait_tick(input bit div1, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < TICK_BUDGET && !seen; i++) begin
         step();
         seen = div1 ? ft1 : ft4;
      end
      check({tag, "_tick_seen"}, 32'(seen), 1);
   endtask

   // Called on the sample where ft4 is high; walks digits 0..3 of the new frame.
   task automatic check_frame(input glyphs_t exp, input bit chg, input logic [15:0] nd,
                              input string tag);
      logic [3:0] ea;
      for (int k = 0; k < 4; k++) begin
         repeat (k == 0 ? 1 : 4) step();
         ea = ~(4'b0001 << k);
         check($sformatf("%s_an%0d", tag, k), 32'(an4), 32'(ea));
         check($sformatf("%s_seg%0d", tag, k), 32'(seg4), 32'(exp[k]));
         if (k == 0) check({tag, "_tick_one_cycle"}, 32'(ft4), 0);
         if (chg && k == 1) disp4 = nd;
      end
   endtask

   initial begin
      logic [3:0] ea;
      glyphs_t    g;

      tbl[0] = '{16'h5678, mk(G8, G7, G6, G5), mk(G8, G7, G6, G5)};
      tbl[1] = '{16'hE90F, mk(GF, G0, G9, GE), mk(GF, G0, G9, GE)};
      tbl[2] = '{16'h8A01, mk(G1, G0, GA, G8), mk(G1, G0, GA, G8)};
      tbl[3] = '{16'h0050, mk(G0, G5, G0, G0), mk(G0, G5, OFF, OFF)};
      tbl[4] = '{16'h0000, mk(G0, G0, G0, G0), mk(G0, OFF, OFF, OFF)};
      tbl[5] = '{16'h1234, mk(G4, G3, G2, G1), mk(G4, G3, G2, G1)};

      rst4 = 1'b1; rst1 = 1'b1;
      disp4 = 16'h1234; disp1 = 16'hFFFF;
      repeat (3) step();
      check("rst_an4", 32'(an4), 32'(4'b1111));
      check("rst_seg4", 32'(seg4), 32'(OFF));
      check("rst_tick4", 32'(ft4), 0);
      check("rst_an1", 32'(an1), 32'(4'b1111));
      check("rst_seg1", 32'(seg1), 32'(OFF));
      check("rst_tick1", 32'(ft1), 0);

      // First edge after release: digit 0 of the all-zero shadow.
      rst4 = 1'b0; rst1 = 1'b0;
      step();
      check("rel_an4", 32'(an4), 32'(4'b1110));
      check("rel_seg4", 32'(seg4), 32'(G0));
      check("rel_tick4", 32'(ft4), 0);
      check("rel_an1", 32'(an1), 32'(4'b1110));
      check("rel_seg1", 32'(seg1), 32'(G0));
      // Shadow still zero on digit 1 even though display is 1234.
      repeat (4) step();
      check("pre_an4", 32'(an4), 32'(4'b1101));
`ifdef SEG7_BLANK_EN
      check("pre_seg4", 32'(seg4), 32'(OFF));
`else
      check("pre_seg4", 32'(seg4), 32'(G0));
`endif

      // 1234 frame; switch to ABCD while digit 1 is active.
      wait_tick(1'b0, "f1234");
      check_frame(mk(G4, G3, G2, G1), 1'b1, 16'hABCD, "f1234");
      wait_tick(1'b0, "fabcd");
      check_frame(mk(GD, GC, GB, GA), 1'b0, 16'h0000, "fabcd");

      for (int i = 0; i < 6; i++) begin
         disp4 = tbl[i].disp;
         wait_tick(1'b0, $sformatf("tbl%0d", i));
         g = pick(tbl[i]);
         check_frame(g, 1'b0, 16'h0000, $sformatf("tbl%0d", i));
      end

      // Reset while index 2 is active abandons the frame.
      wait_tick(1'b0, "midrst");
      repeat (9) step();
      check("midrst_an_before", 32'(an4), 32'(4'b1011));
      rst4 = 1'b1;
      step();
      check("midrst_an", 32'(an4), 32'(4'b1111));
      check("midrst_seg", 32'(seg4), 32'(OFF));
      check("midrst_tick", 32'(ft4), 0);
      rst4 = 1'b0;
      step();
      check("midrst_rel_an", 32'(an4), 32'(4'b1110));
      check("midrst_rel_seg", 32'(seg4), 32'(G0));
      check("midrst_rel_tick", 32'(ft4), 0);

      // REFRESH_DIV=1: index every cycle, tick every 4th cycle, F on every digit.
      rst1 = 1'b1;
      step();
      rst1 = 1'b0;
      wait_tick(1'b1, "div1");
      for (int i = 1; i <= 16; i++) begin
         step();
         ea = ~(4'b0001 << ((i - 1) % 4));
         check($sformatf("div1_an_c%0d", i), 32'(an1), 32'(ea));
         check($sformatf("div1_seg_c%0d", i), 32'(seg1), 32'(GF));
         check($sformatf("div1_tick_c%0d", i), 32'(ft1), 32'((i % 4) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_mux.md
SEG7_MUX -- requirements
Module: seg7_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clk cycles each digit stays lit (legal 1..2^20).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port display  input  16  four hex nibbles from the scroll stage; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-005 SHALL have port an  output  4  digit anode enables, active-low, one-hot-low when lit.
REQ-006 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-007 SHALL have port frame_tick  output  1  one-cycle pulse marking each new display snapshot.

Function
REQ-008 SHALL run prescaler 0..REFRESH_DIV-1, wrapping to 0; width = clog2(REFRESH_DIV), minimum 1 bit.
REQ-009 SHALL advance 2-bit digit index 0->1->2->3->0 on the cycle the prescaler is at terminal count.
REQ-010 SHALL copy display into a shadow register only when index wraps 3->0; mid-frame display changes SHALL NOT appear until the next frame.
REQ-011 SHALL pulse frame_tick high for exactly one cycle, registered, on the edge the shadow is loaded.
REQ-012 SHALL register an and seg; they SHALL reflect the index and shadow value one cycle after the index changes.
REQ-013 SHALL drive an[i]=0 for the active index i and 1 for all other digits; no two digits lit in any cycle.
REQ-014 SHALL decode nibbles to standard hex glyphs: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; remaining values per the shared package table.
REQ-015 With REFRESH_DIV=1, SHALL advance index every cycle and pulse frame_tick every 4th cycle.

Reset
REQ-016 While rst=1: prescaler=0, index=0, shadow=16'h0000, an=4'b1111, seg=7'b1111111, frame_tick=0.
REQ-017 On the first edge after rst falls, SHALL drive an=4'b1110, seg=1000000 (digit 0, shadow 0), shadow still 0.
REQ-018 rst asserted mid-frame SHALL abandon the frame with no frame_tick and blank outputs on the next edge.

Configuration
REQ-019 Macro SEG7_BLANK_EN: when defined, digits 3..1 SHALL drive seg=1111111 (anode still cycled) if that nibble and all higher nibbles of the shadow are 0; digit 0 SHALL never be blanked.
REQ-020 Without SEG7_BLANK_EN, all four digits SHALL always show their glyph.

Structure
REQ-021 Package seg7_pkg SHALL hold the 16-entry hex-to-segment constant table, SEG_OFF (7'b1111111), AN_OFF (4'b1111) and the 2-bit digit-index typedef.
REQ-022 Combinational sub-module seg7_decode (4-bit nibble in, 7-bit active-low segments out) SHALL be instantiated once on the selected nibble.

Verification
REQ-023 REFRESH_DIV=4, display=16'h1234, rst pulse -> an sequence 1110,1101,1011,0111 every 4 cycles after first frame_tick; seg shows 4,3,2,1.
REQ-024 Change display 16'h1234->16'hABCD while index=1 -> current frame still shows 1234; next frame shows ABCD starting on the cycle after frame_tick.
REQ-025 REFRESH_DIV=1, display=16'hFFFF -> frame_tick every 4 cycles, seg=0001110 every cycle after first snapshot, an never two digits low.
REQ-026 rst asserted at index=2 -> next edge an=1111, seg=1111111, frame_tick=0; after release an=1110, seg=1000000.
REQ-027 SEG7_BLANK_EN defined, display=16'h0050 -> digits 3 and 2 blank (seg=1111111), digit 1 shows 5, digit 0 shows 0; display=16'h0000 -> only digit 0 shows 0.
